hazard_stall_unit: RTL
======================

// Module: hazard_stall_unit
// PURPOSE
//  Detects load-use and load-branch hazards that operand forwarding cannot resolve, per hardware thread (hart).
//  Sits in ID beside the forwarding unit: it reads the same ID/EX/MEM pipeline tags.
//  Drives PC/IF-ID write enables, bubble insertion into ID/EX and IF flush on a taken ID-stage branch.
//  Keeps per-hart saturating stall-cycle counters for performance monitoring.
// PARAMETERS
//  NHARTS  4   number of hardware threads
//  HID_W   2   hart ID width, clog2(NHARTS)
//  CNT_W   16  width of each per-hart stall counter
// PORTS
//  clk             in   1             clock, all state on rising edge
//  reset           in   1             synchronous, active-high
//  RegisterRS1_ID  in   5             rs1 of instruction in ID
//  RegisterRS2_ID  in   5             rs2 of instruction in ID
//  UseRS1_ID       in   1             ID instruction reads rs1
//  UseRS2_ID       in   1             ID instruction reads rs2
//  Branch_ID       in   1             ID instruction is branch/jalr (compares in ID)
//  BranchTaken_ID  in   1             ID branch resolved taken
//  mhartID_ID      in   HID_W         hart of ID instruction
//  mhartID_IF      in   HID_W         hart of IF instruction
//  MemRead_EX      in   1             EX instruction is a load
//  RegWrite_EX     in   1             EX instruction writes rd
//  Waddr_EX        in   5             rd of EX instruction
//  mhartID_EX      in   HID_W         hart of EX instruction
//  MemRead_Mem     in   1             MEM instruction is a load
//  Waddr_Mem       in   5             rd of MEM instruction
//  mhartID_Mem     in   HID_W         hart of MEM instruction
//  clr_cnt         in   1             synchronous clear of all stall counters
//  PCWrite         out  1             1 = PC may advance
//  IFIDWrite       out  1             1 = IF/ID register may load
//  Bubble_EX       out  1             1 = load NOP into ID/EX
//  FlushIF         out  1             1 = squash IF/ID contents
//  StallCnt        out  NHARTS*CNT_W  per-hart stall cycles, hart h at [h*CNT_W +: CNT_W]
// BEHAVIOUR
//  Match(rsX, Wa, hid): UseRSX_ID && Wa!=0 && Wa==rsX && hid==mhartID_ID; different harts never hazard.
//  Hazard classes, evaluated only in IDLE:
//   LU:  MemRead_EX && RegWrite_EX && Match(any rs, Waddr_EX, mhartID_EX) && !Branch_ID -> 1 stall cycle
//   LB2: MemRead_EX && RegWrite_EX && Match(any rs, Waddr_EX, mhartID_EX) && Branch_ID -> 2 stall cycles
//   LB1: MemRead_Mem && Match(any rs, Waddr_Mem, mhartID_Mem) && Branch_ID, no LB2 -> 1 stall cycle
//   Non-load EX/MEM producers are covered by forwarding and never stall.
//  FSM: IDLE, HOLD; 2-bit remaining count rem.
//   IDLE: hazard -> stall asserted combinationally in the same cycle.
//   IDLE with 1-cycle hazard -> stays IDLE; the bubble clears the hazard next cycle.
//   IDLE with LB2 -> HOLD, rem=1.
//   HOLD: stall asserted unconditionally, no re-detection. rem==1 -> IDLE.
//  stall => PCWrite=0, IFIDWrite=0, Bubble_EX=1; otherwise PCWrite=1, IFIDWrite=1, Bubble_EX=0.
//  FlushIF = BranchTaken_ID && Branch_ID && !stall && mhartID_IF==mhartID_ID. A stalled branch is never flushed-on.
//  Counters:
//   Each stall cycle increments StallCnt[mhartID_ID].
//   Saturate at 2^CNT_W-1, no wrap.
//   clr_cnt zeroes all counters; clr_cnt wins over a simultaneous increment.
//  Reset:
//   While reset=1: PCWrite=1, IFIDWrite=1, Bubble_EX=0, FlushIF=0.
//   After the edge: state=IDLE, rem=0, all StallCnt=0.
//   Reset during HOLD aborts the stall immediately.
//  All outputs are combinational from state plus inputs; zero-cycle latency.
// TESTING
//  lw x5 (hart1) in EX, add rs1=x5 (hart1) in ID -> 1 cycle PCWrite=0, Bubble_EX=1; StallCnt[1]=1.
//  lw x5 (hart2) in EX, add rs1=x5 (hart0) in ID -> no stall, all counters 0.
//  lw x7 in EX, beq rs2=x7 same hart -> stall 2 consecutive cycles (IDLE->HOLD->IDLE), then FlushIF=1 if taken.
//  lw x0 in EX, add rs1=x0 -> no stall; addi x5 in EX, beq rs1=x5 -> no stall.
//  Taken beq hart3 in ID, mhartID_IF=0 -> FlushIF=0; with mhartID_IF=3 -> FlushIF=1.
//  CNT_W=2: force 5 stalls on hart0 -> saturates at 3; clr_cnt concurrent with a stall -> 0; reset in HOLD -> PCWrite=1.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: detects load-use and load-branch hazards that forwarding
// cannot cover, per hart. It drives the PC and IF/ID write enables, the ID/EX
// bubble and the IF flush for a taken ID-stage branch. It also keeps per-hart
// saturating stall-cycle counters.
module hazard_stall_unit #(
    parameter int NHARTS = 4,
    parameter int HID_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              RegisterRS1_ID,
    input  logic [4:0]              RegisterRS2_ID,
    input  logic                    UseRS1_ID,
    input  logic                    UseRS2_ID,
    input  logic                    Branch_ID,
    input  logic                    BranchTaken_ID,
    input  logic [HID_W-1:0]        mhartID_ID,
    input  logic [HID_W-1:0]        mhartID_IF,
    input  logic                    MemRead_EX,
    input  logic                    RegWrite_EX,
    input  logic [4:0]              Waddr_EX,
    input  logic [HID_W-1:0]        mhartID_EX,
    input  logic                    MemRead_Mem,
    input  logic [4:0]              Waddr_Mem,
    input  logic [HID_W-1:0]        mhartID_Mem,
    input  logic                    clr_cnt,
    output logic                    PCWrite,
    output logic                    IFIDWrite,
    output logic                    Bubble_EX,
    output logic                    FlushIF,
    output logic [NHARTS*CNT_W-1:0] StallCnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_rem;
    logic [CNT_W-1:0] r_cnt [NHARTS];

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_lu;
    logic w_lb2;
    logic w_lb1;
    logic w_stall;

    // A producer hazards a source register only when it really writes a
    // non-zero register of the same hart that the ID instruction reads.
    function automatic logic f_match(
        input logic             use_rs,
        input logic [4:0]       rs,
        input logic [4:0]       wa,
        input logic [HID_W-1:0] hid,
        input logic [HID_W-1:0] id_hid
    );
        f_match = use_rs && (wa != 5'd0) && (wa == rs) && (hid == id_hid);
    endfunction

    // Hazard classification from the EX and MEM pipeline tags.
    always_comb begin
        w_ex_hit  = MemRead_EX && RegWrite_EX &&
                    (f_match(UseRS1_ID, RegisterRS1_ID, Waddr_EX, mhartID_EX, mhartID_ID) ||
                     f_match(UseRS2_ID, RegisterRS2_ID, Waddr_EX, mhartID_EX, mhartID_ID));
        w_mem_hit = MemRead_Mem &&
                    (f_match(UseRS1_ID, RegisterRS1_ID, Waddr_Mem, mhartID_Mem, mhartID_ID) ||
                     f_match(UseRS2_ID, RegisterRS2_ID, Waddr_Mem, mhartID_Mem, mhartID_ID));
        w_lu      = w_ex_hit && !Branch_ID;
        w_lb2     = w_ex_hit && Branch_ID;
        w_lb1     = w_mem_hit && Branch_ID && !w_lb2;
    end

    // Stall decision: fresh detection in IDLE, unconditional while holding;
    // reset forces the pipeline free-running.
    always_comb begin
        w_stall = 1'b0;
        if (reset) begin
            w_stall = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: w_stall = w_lu || w_lb2 || w_lb1;
                ST_HOLD: w_stall = 1'b1;
                default: w_stall = 1'b0;
            endcase
        end
    end

    // Pipeline control outputs; a stalled branch never triggers a flush.
    always_comb begin
        PCWrite   = !w_stall;
        IFIDWrite = !w_stall;
        Bubble_EX = w_stall;
        FlushIF   = 1'b0;
        if (reset) begin
            FlushIF = 1'b0;
        end else begin
            FlushIF = BranchTaken_ID && Branch_ID && !w_stall && (mhartID_IF == mhartID_ID);
        end
    end

    // Stall sequencer: a load feeding a branch from EX needs a second cycle,
    // which HOLD supplies without re-examining the pipeline tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rem   <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lb2) begin
                        r_state <= ST_HOLD;
                        r_rem   <= 2'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_rem   <= 2'd0;
                    end
                end
                ST_HOLD: begin
                    if (r_rem == 2'd1) begin
                        r_state <= ST_IDLE;
                        r_rem   <= 2'd0;
                    end else begin
                        r_state <= ST_HOLD;
                        r_rem   <= r_rem - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rem   <= 2'd0;
                end
            endcase
        end
    end

    // Per-hart stall counters, saturating; clearing overrides counting.
    always_ff @(posedge clk) begin
        for (int h = 0; h < NHARTS; h++) begin
            if (reset || clr_cnt) begin
                r_cnt[h] <= {CNT_W{1'b0}};
            end else if (w_stall && (mhartID_ID == HID_W'(h)) && (r_cnt[h] != CNT_MAX)) begin
                r_cnt[h] <= r_cnt[h] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt[h] <= r_cnt[h];
            end
        end
    end

    // Flatten the counters, hart h occupying [h*CNT_W +: CNT_W].
    always_comb begin
        StallCnt = {(NHARTS*CNT_W){1'b0}};
        for (int h = 0; h < NHARTS; h++) begin
            StallCnt[h*CNT_W +: CNT_W] = r_cnt[h];
        end
    end

endmodule
